fp_matrix_store_nios: RTL and testbench

Avalon-MM write-master DMA that copies an N×N single-precision matrix from the on-chip matrix RAM back to SDRAM. It is started by a Nios II custom instruction and signals completion with an interrupt. Completion is acknowledged through an Avalon slave read. It is the store-side counterpart of the determinant unit's SDRAM load path and shares the same status-code convention.

---
 rtl/fp_matrix_store_nios_if.sv | 24 ++
 rtl/fp_matrix_store_nios.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_fp_matrix_store_nios.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_matrix_store_nios_if.sv
// Avalon-MM write-master bus for the matrix store DMA.
// The master drives address/write/writedata; the slave answers with waitrequest.
interface fp_matrix_store_nios_if #(
    parameter int ADDR_W = 24
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;

    modport master (
        output address,
        output write,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        output waitrequest
    );
endinterface

// File: rtl/fp_matrix_store_nios.sv
// fp_matrix_store_nios: copies an N x N single-precision matrix from the
// on-chip matrix RAM to SDRAM over an Avalon-MM write master. Started by a
// Nios II custom instruction, completion signalled by irq and acknowledged
// through a slave read that returns the number of words written.
// Optional build macro FP_STORE_CHECKSUM_EN: appends an XOR checksum word
// after the matrix and reports total+1 words.
module fp_matrix_store_nios #(
    parameter logic [5:0] DEFAULT_DIMENSION = 6'd16,
    parameter int         MAX_DIMENSION     = 32,
    parameter int         ADDR_W            = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    // custom instruction
    input  logic                  clk_en_i,
    input  logic                  start_i,
    input  logic [31:0]           dataa_i,
    input  logic [31:0]           datab_i,
    output logic                  done_o,
    output logic [31:0]           result_o,
    // Avalon write master
    fp_matrix_store_nios_if.master avm,
    // matrix RAM read port (1-cycle read latency)
    output logic [9:0]            ram_rdaddress_o,
    output logic                  ram_rden_o,
    input  logic [31:0]           ram_q_i,
    // Avalon slave (interrupt acknowledge)
    input  logic                  result_read_i,
    output logic [31:0]           result_readdata_o,
    output logic                  irq_o
);

    localparam logic [31:0] ST_READY    = 32'd0;
    localparam logic [31:0] ST_BUSY     = 32'd1;
    localparam logic [31:0] ST_IRQ_WAIT = 32'd3;
    localparam logic [31:0] ST_REJECT   = 32'd98;
    localparam logic [31:0] ST_ACCEPT   = 32'd99;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_IRQ_WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [10:0]       total_q, total_d;
    logic [10:0]       rd_cnt_q, rd_cnt_d;
    logic [10:0]       wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              write_q, write_d;
    logic [31:0]       writedata_q, writedata_d;
    logic              irq_q, irq_d;
    logic              done_q, done_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              rd_valid_q;

`ifdef FP_STORE_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
    logic              csum_phase_q, csum_phase_d;
`endif

    // two-entry prefetch FIFO between the RAM read port and the write master
    logic [31:0]       fifo_mem_q [2];
    logic              fifo_wptr_q, fifo_rptr_q;
    logic [1:0]        fifo_cnt_q;
    logic              fifo_empty;
    logic              fifo_push, fifo_pop, fifo_clr;
    logic              word_avail, word_take;
    logic [31:0]       head_word;

    logic              start_fire;
    logic              rd_issue;
    logic              accept_dim;
    logic [5:0]        dim_sel;
    logic [10:0]       wr_cnt_inc;

    logic              unused_ok;
    assign unused_ok = ^dataa_i[31:ADDR_W];

    assign start_fire = clk_en_i & start_i;
    assign wr_cnt_inc = wr_cnt_q + 11'd1;

    // Fall-through head: when the FIFO is empty the word returning from RAM
    // this cycle can go straight to the bus, saving a cycle of latency.
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign word_avail = !fifo_empty || rd_valid_q;
    assign head_word  = fifo_empty ? ram_q_i : fifo_mem_q[fifo_rptr_q];
    assign fifo_push  = rd_valid_q && !(word_take && fifo_empty);
    assign fifo_pop   = word_take && !fifo_empty;

    assign ram_rden_o      = rd_issue;
    assign ram_rdaddress_o = rd_issue ? rd_cnt_q[9:0] : 10'd0;

    assign avm.address       = address_q;
    assign avm.write         = write_q;
    assign avm.writedata     = writedata_q;
    assign done_o            = done_q;
    assign result_o          = result_q;
    assign result_readdata_o = readdata_q;
    assign irq_o             = irq_q;

    // Next-state, custom-instruction response, prefetch and bus sequencing.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        total_d     = total_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        address_d   = address_q;
        write_d     = write_q;
        writedata_d = writedata_q;
        irq_d       = irq_q;
        done_d      = 1'b0;
        result_d    = 32'd0;
        readdata_d  = 32'd0;
        rd_issue    = 1'b0;
        word_take   = 1'b0;
        fifo_clr    = 1'b0;
        accept_dim  = 1'b0;
        dim_sel     = DEFAULT_DIMENSION;
`ifdef FP_STORE_CHECKSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_fire) begin
                    done_d = 1'b1;
                    if (datab_i == 32'd0) begin
                        accept_dim = 1'b1;
                    end else if (datab_i == 32'd1) begin
                        result_d = ST_READY;
                    end else if (datab_i > 32'(MAX_DIMENSION)) begin
                        result_d = ST_REJECT;
                    end else begin
                        accept_dim = 1'b1;
                        dim_sel    = datab_i[5:0];
                    end
                    if (accept_dim) begin
                        result_d = ST_ACCEPT;
                        base_d   = dataa_i[ADDR_W-1:0];
                        total_d  = 11'(dim_sel) * 11'(dim_sel);
                        rd_cnt_d = 11'd0;
                        wr_cnt_d = 11'd0;
                        write_d  = 1'b0;
                        fifo_clr = 1'b1;
                        state_d  = S_WRITE;
`ifdef FP_STORE_CHECKSUM_EN
                        csum_d       = 32'd0;
                        csum_phase_d = 1'b0;
`endif
                    end
                end
            end

            S_WRITE: begin
                if (start_fire) begin
                    done_d   = 1'b1;
                    result_d = ST_BUSY;
                end
                // Only read when the word has somewhere to land: FIFO
                // occupancy plus the read already in flight must stay below 2.
                if ((rd_cnt_q < total_q) &&
                    (({1'b0, fifo_cnt_q} + {2'b00, rd_valid_q}) < 3'd2)) begin
                    rd_issue = 1'b1;
                    rd_cnt_d = rd_cnt_q + 11'd1;
                end
                if (!write_q) begin
                    if (word_avail) begin
                        word_take   = 1'b1;
                        writedata_d = head_word;
                        address_d   = base_q + ADDR_W'({wr_cnt_q, 2'b00});
                        write_d     = 1'b1;
                    end
                end else if (!avm.waitrequest) begin
`ifdef FP_STORE_CHECKSUM_EN
                    if (csum_phase_q) begin
                        write_d      = 1'b0;
                        irq_d        = 1'b1;
                        csum_phase_d = 1'b0;
                        state_d      = S_IRQ_WAIT;
                    end else
`endif
                    begin
                        wr_cnt_d = wr_cnt_inc;
`ifdef FP_STORE_CHECKSUM_EN
                        csum_d = csum_q ^ writedata_q;
`endif
                        if (wr_cnt_inc == total_q) begin
`ifdef FP_STORE_CHECKSUM_EN
                            writedata_d  = csum_q ^ writedata_q;
                            address_d    = base_q + ADDR_W'({total_q, 2'b00});
                            csum_phase_d = 1'b1;
`else
                            write_d = 1'b0;
                            irq_d   = 1'b1;
                            state_d = S_IRQ_WAIT;
`endif
                        end else if (word_avail) begin
                            word_take   = 1'b1;
                            writedata_d = head_word;
                            address_d   = base_q + ADDR_W'({wr_cnt_inc, 2'b00});
                        end else begin
                            write_d = 1'b0;
                        end
                    end
                end
            end

            S_IRQ_WAIT: begin
                if (start_fire) begin
                    done_d   = 1'b1;
                    result_d = ST_IRQ_WAIT;
                end
                if (result_read_i) begin
`ifdef FP_STORE_CHECKSUM_EN
                    readdata_d = 32'(total_q) + 32'd1;
`else
                    readdata_d = 32'(total_q);
`endif
                    irq_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            total_q     <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            address_q   <= '0;
            write_q     <= 1'b0;
            writedata_q <= '0;
            irq_q       <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            readdata_q  <= '0;
            rd_valid_q  <= 1'b0;
`ifdef FP_STORE_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            total_q     <= total_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            address_q   <= address_d;
            write_q     <= write_d;
            writedata_q <= writedata_d;
            irq_q       <= irq_d;
            done_q      <= done_d;
            result_q    <= result_d;
            readdata_q  <= readdata_d;
            rd_valid_q  <= rd_issue;
`ifdef FP_STORE_CHECKSUM_EN
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || fifo_clr) begin
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            if (fifo_push) fifo_wptr_q <= ~fifo_wptr_q;
            if (fifo_pop)  fifo_rptr_q <= ~fifo_rptr_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);
        end
    end

    // FIFO storage: plain data, no reset needed.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem_q[fifo_wptr_q] <= ram_q_i;
    end

endmodule

// File: tb/tb_fp_matrix_store_nios.sv
// Randomized self-checking bench for fp_matrix_store_nios. A RAM model feeds
// the DUT, a bus responder drives waitrequest and captures accepted writes,
// and the expected write list is built from base + 4*i / RAM[i].
module tb_fp_matrix_store_nios;
    localparam int ADDR_W = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic        done;
    logic [31:0] result;
    logic [9:0]  ram_rdaddress;
    logic        ram_rden;
    logic [31:0] ram_q = '0;
    logic        result_read = 1'b0;
    logic [31:0] result_readdata;
    logic        irq;

    fp_matrix_store_nios_if #(.ADDR_W(ADDR_W)) avm ();

    fp_matrix_store_nios #(.ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .clk_en_i          (clk_en),
        .start_i           (start),
        .dataa_i           (dataa),
        .datab_i           (datab),
        .done_o            (done),
        .result_o          (result),
        .avm               (avm),
        .ram_rdaddress_o   (ram_rdaddress),
        .ram_rden_o        (ram_rden),
        .ram_q_i           (ram_q),
        .result_read_i     (result_read),
        .result_readdata_o (result_readdata),
        .irq_o             (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_mem [0:1023];
    always @(posedge clk) if (ram_rden) ram_q <= ram_mem[ram_rdaddress];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // bus responder / write monitor state
    logic [55:0] cap_q[$];
    int acc_cnt = 0, first_wr_cyc = -1, last_acc_cyc = 0, stalls_seen = 0;
    int wait_pct = 0, stall_left = 0;
    bit prev_stall = 0;
    logic [55:0] prev_word;

    initial avm.waitrequest = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            avm.waitrequest = 1'b0;
            prev_stall = 0;
        end else begin
            if (stall_left > 0 && avm.write && acc_cnt == 1) begin
                avm.waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm.waitrequest = ($urandom_range(0, 99) < wait_pct);
            end
            if (prev_stall)
                chk("hold", {7'd0, avm.write, avm.address, avm.writedata}, {8'd1, prev_word});
            if (avm.write && first_wr_cyc < 0) first_wr_cyc = cyc;
            if (avm.write && avm.waitrequest) stalls_seen++;
            if (avm.write && !avm.waitrequest) begin
                cap_q.push_back({avm.address, avm.writedata});
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            prev_stall = avm.write && avm.waitrequest;
            prev_word  = {avm.address, avm.writedata};
        end
    end

    int start_cyc = 0;

    task automatic ci(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res);
        @(negedge clk);
        dataa = a; datab = b; start = 1'b1; clk_en = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0; clk_en = 1'b0;
        chk("ci_done", {63'd0, done}, 64'd1);
        res = result;
    endtask

    task automatic do_read(input logic [31:0] exp);
        @(negedge clk);
        result_read = 1'b1;
        @(negedge clk);
        result_read = 1'b0;
        chk("readdata", {32'd0, result_readdata}, {32'd0, exp});
        chk("irq_low", {63'd0, irq}, 64'd0);
    endtask

    task automatic clear_mon(input int pct, input int stall);
        cap_q.delete();
        acc_cnt = 0; first_wr_cyc = -1; stalls_seen = 0;
        wait_pct = pct; stall_left = stall;
    endtask

    // One full transfer: fill RAM, start, optionally poke start mid-flight,
    // wait for irq, compare writes against the model, acknowledge.
    task automatic run_xfer(input logic [23:0] base, input logic [31:0] dimb, input int pct,
                            input int stall, input bit poke, input bit timing, input bit seq);
        int n, total, s0, irq_cyc;
        bit got;
        logic [31:0] r;
        logic [23:0] a;
        logic [31:0] x;
        logic [55:0] exp_q[$];
        n = (dimb == 0) ? 16 : int'(dimb);
        total = n * n;
        x = 32'd0;
        for (int i = 0; i < total; i++) begin
            ram_mem[i] = seq ? 32'h11 * (i + 1) : $urandom;
            a = base + 24'(4 * i);
            exp_q.push_back({a, ram_mem[i]});
            x = x ^ ram_mem[i];
        end
`ifdef FP_STORE_CHECKSUM_EN
        a = base + 24'(4 * total);
        exp_q.push_back({a, x});
`endif
        clear_mon(pct, stall);
        ci({8'd0, base}, dimb, r);
        s0 = start_cyc;
        chk("start_ack", {32'd0, r}, 64'd99);
        if (poke) begin
            ci($urandom, $urandom, r);
            chk("busy_ack", {32'd0, r}, 64'd1);
        end
        got = 0;
        irq_cyc = 0;
        for (int k = 0; k < 20000 && !got; k++) begin
            @(negedge clk);
            if (irq) begin got = 1; irq_cyc = cyc; end
        end
        chk("irq_rise", {63'd0, got}, 64'd1);
        if (got && !poke) chk("irq_lat", 64'(irq_cyc - last_acc_cyc), 64'd1);
        chk("wr_count", 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cap_q.size()) chk($sformatf("wr%0d", i), {8'd0, cap_q[i]}, {8'd0, exp_q[i]});
        if (timing) begin
            chk("first_lat", 64'(first_wr_cyc - s0), 64'd3);
            chk("b2b", 64'(last_acc_cyc - first_wr_cyc), 64'(exp_q.size() - 1));
        end
        if (stall > 0) chk("stalls", 64'(stalls_seen), 64'(stall));
        if (poke) begin
            ci($urandom, $urandom, r);
            chk("irqwait_ack", {32'd0, r}, 64'd3);
        end
        do_read(32'(exp_q.size()));
        $display("xfer base=%06h N=%0d pct=%0d stall=%0d writes=%0d", base, n, pct, stall, cap_q.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        bit hit;
        for (int i = 0; i < 1024; i++) ram_mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_done",   {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_bus",    {7'd0, avm.write, avm.address, avm.writedata}, 64'd0);
        chk("rst_ram",    {53'd0, ram_rden, ram_rdaddress}, 64'd0);
        chk("rst_slave",  {31'd0, irq, result_readdata}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // clk_en low: start must be ignored
        start = 1'b1; datab = 32'd2;
        @(negedge clk);
        start = 1'b0;
        chk("clk_en_gate", {63'd0, done}, 64'd0);

        do_read(32'd0);
        run_xfer(24'h000100, 32'd2, 0, 0, 0, 1, 1);
        run_xfer(24'h000100, 32'd2, 0, 3, 0, 0, 1);
        run_xfer($urandom, 32'd8, 30, 0, 1, 0, 0);

        ci($urandom, 32'd1, r);
        chk("status_query", {32'd0, r}, 64'd0);
        clear_mon(0, 0);
        ci($urandom, 32'd33, r);
        chk("reject", {32'd0, r}, 64'd98);
        repeat (10) @(negedge clk);
        chk("reject_nowr", 64'(acc_cnt), 64'd0);
        run_xfer($urandom, 32'd0, 30, 0, 0, 0, 0);

        // reset in the middle of an N=4 transfer
        clear_mon(0, 0);
        ci(32'h000400, 32'd4, r);
        chk("rst_xfer_ack", {32'd0, r}, 64'd99);
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge clk);
            if (acc_cnt >= 5) hit = 1;
        end
        chk("rst_xfer_5wr", {63'd0, hit}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_write", {63'd0, avm.write}, 64'd0);
        chk("midrst_irq",   {63'd0, irq}, 64'd0);
        reset = 1'b0;
        ci($urandom, 32'd1, r);
        chk("midrst_idle", {32'd0, r}, 64'd0);
        run_xfer(24'h000200, 32'd2, 0, 0, 0, 1, 0);

        run_xfer(24'hFFFFF8, 32'd2, 0, 0, 0, 1, 1);
        for (int t = 0; t < 4; t++)
            run_xfer($urandom, 32'($urandom_range(2, 6)), $urandom_range(0, 60), 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
